// File: rtl/sdram_arbiter.sv
// Two-port arbiter in front of the SDRAM controller user interface, with a read-response timeout.
// Optional macro SDRAM_ARB_RR_EN: round-robin on simultaneous requests (default: port 0 priority).
module sdram_arbiter #(
  parameter int unsigned       ADDR_W     = 23,
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       RD_TIMEOUT = 64,
  parameter logic [DATA_W-1:0] TO_DATA    = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_valid,
  input  logic              p0_rw,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ready,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_err,
  input  logic              p1_valid,
  input  logic              p1_rw,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ready,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,
  output logic              sd_in_valid,
  output logic              sd_rw,
  output logic [ADDR_W-1:0] sd_user_addr,
  output logic [DATA_W-1:0] sd_data_in,
  input  logic              sd_busy,
  input  logic [DATA_W-1:0] sd_data_out,
  input  logic              sd_out_valid
);

  localparam int unsigned     CntW   = $clog2(RD_TIMEOUT);
  localparam logic [CntW-1:0] CntMax = CntW'(RD_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitRd} state_e;

  state_e              state_q, state_d;
  logic                grant_q, grant_d;
  logic                last_q, last_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                in_valid_q, in_valid_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [1:0]          ready_q, ready_d;
  logic [1:0]          rvalid_q, rvalid_d;
  logic [1:0]          err_q, err_d;
  logic [DATA_W-1:0]   rdata_q [2];
  logic [DATA_W-1:0]   rdata_d [2];
  logic                pick;

  always_comb begin
`ifdef SDRAM_ARB_RR_EN
    pick = (p0_valid && p1_valid) ? ~last_q : ~p0_valid;
`else
    pick = ~p0_valid;
`endif
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    in_valid_d = 1'b0;
    rw_d       = rw_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ready_d    = 2'b00;
    rvalid_d   = 2'b00;
    err_d      = err_q;
    rdata_d    = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (!sd_busy && (p0_valid || p1_valid)) begin
          grant_d       = pick;
          rw_d          = pick ? p1_rw    : p0_rw;
          addr_d        = pick ? p1_addr  : p0_addr;
          wdata_d       = pick ? p1_wdata : p0_wdata;
          in_valid_d    = 1'b1;
          ready_d[pick] = 1'b1;
          state_d       = StIssue;
        end
      end
      StIssue: begin
        last_d = grant_q;
        if (rw_q) begin
          state_d = StIdle;
        end else begin
          state_d = StWaitRd;
          cnt_d   = '0;
        end
      end
      StWaitRd: begin
        // A response arriving on the timeout cycle still counts as a normal response.
        if (sd_out_valid) begin
          rvalid_d[grant_q] = 1'b1;
          rdata_d[grant_q]  = sd_data_out;
          err_d[grant_q]    = 1'b0;
          state_d           = StIdle;
        end else if (cnt_q == CntMax) begin
          rvalid_d[grant_q] = 1'b1;
          rdata_d[grant_q]  = TO_DATA;
          err_d[grant_q]    = 1'b1;
          state_d           = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      grant_q    <= 1'b0;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      in_valid_q <= 1'b0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ready_q    <= 2'b00;
      rvalid_q   <= 2'b00;
      err_q      <= 2'b00;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      in_valid_q <= in_valid_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ready_q    <= ready_d;
      rvalid_q   <= rvalid_d;
      err_q      <= err_d;
      rdata_q[0] <= rdata_d[0];
      rdata_q[1] <= rdata_d[1];
    end
  end

  assign sd_in_valid  = in_valid_q;
  assign sd_rw        = rw_q;
  assign sd_user_addr = addr_q;
  assign sd_data_in   = wdata_q;
  assign p0_ready     = ready_q[0];
  assign p1_ready     = ready_q[1];
  assign p0_rvalid    = rvalid_q[0];
  assign p1_rvalid    = rvalid_q[1];
  assign p0_err       = err_q[0];
  assign p1_err       = err_q[1];
  assign p0_rdata     = rdata_q[0];
  assign p1_rdata     = rdata_q[1];

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed self-checking bench for sdram_arbiter; the controller side is driven by hand.
module tb_sdram_arbiter;

  localparam int ADDR_W = 23;
  localparam int DATA_W = 32;
  localparam int RD_TO  = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              p0_valid = 0, p0_rw = 0, p1_valid = 0, p1_rw = 0;
  logic [ADDR_W-1:0] p0_addr = '0, p1_addr = '0;
  logic [DATA_W-1:0] p0_wdata = '0, p1_wdata = '0;
  logic              p0_ready, p0_rvalid, p0_err, p1_ready, p1_rvalid, p1_err;
  logic [DATA_W-1:0] p0_rdata, p1_rdata;
  logic              sd_in_valid, sd_rw;
  logic [ADDR_W-1:0] sd_user_addr;
  logic [DATA_W-1:0] sd_data_in;
  logic              sd_busy = 0, sd_out_valid = 0;
  logic [DATA_W-1:0] sd_data_out = '0;

  int total = 0;
  int bad   = 0;

  sdram_arbiter dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_rw(p0_rw), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ready(p0_ready), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_valid(p1_valid), .p1_rw(p1_rw), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ready(p1_ready), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .sd_in_valid(sd_in_valid), .sd_rw(sd_rw), .sd_user_addr(sd_user_addr),
    .sd_data_in(sd_data_in), .sd_busy(sd_busy), .sd_data_out(sd_data_out),
    .sd_out_valid(sd_out_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_issue(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (sd_in_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  logic       ok;
  int         hits;
  logic       exp_g;
  logic [7:0] flags;

  initial begin
    // Reset state
    step();
    flags = {sd_in_valid, sd_rw, p0_ready, p0_rvalid, p0_err, p1_ready, p1_rvalid, p1_err};
    check("rst_flags", 64'(flags), 64'h0);
    check("rst_addr", 64'(sd_user_addr), 64'h0);
    check("rst_rdata", {p0_rdata, p1_rdata}, 64'h0);
    rst = 1'b0;
    step();

    // 1: p0 write
    p0_valid = 1; p0_rw = 1; p0_addr = 23'h000100; p0_wdata = 32'h12345678;
    step();
    check("t1_in_valid", 64'(sd_in_valid), 64'h1);
    check("t1_p0_ready", 64'(p0_ready), 64'h1);
    check("t1_p1_ready", 64'(p1_ready), 64'h0);
    check("t1_rw", 64'(sd_rw), 64'h1);
    check("t1_addr", 64'(sd_user_addr), 64'h100);
    check("t1_data", 64'(sd_data_in), 64'h12345678);
    p0_valid = 0;
    step();
    check("t1_pulse_end", 64'({sd_in_valid, p0_ready, p0_rvalid}), 64'h0);
    check("t1_addr_hold", 64'(sd_user_addr), 64'h100);
    step();
    check("t1_no_rvalid", 64'(p0_rvalid), 64'h0);

    // 2: p1 read, response 5 cycles after issue
    p1_valid = 1; p1_rw = 0; p1_addr = 23'h000100;
    wait_issue(ok);
    check("t2_issue", 64'(ok), 64'h1);
    check("t2_p1_ready", 64'(p1_ready), 64'h1);
    check("t2_rw", 64'(sd_rw), 64'h0);
    p1_valid = 0;
    hits = 0;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (p1_rvalid || p0_rvalid) hits++;
    end
    check("t2_early_rvalid", 64'(hits), 64'h0);
    sd_out_valid = 1; sd_data_out = 32'h12345678;
    step();
    sd_out_valid = 0;
    check("t2_p1_rvalid", 64'(p1_rvalid), 64'h1);
    check("t2_p1_rdata", 64'(p1_rdata), 64'h12345678);
    check("t2_p1_err", 64'(p1_err), 64'h0);
    check("t2_p0_rvalid", 64'(p0_rvalid), 64'h0);
    step();
    check("t2_rvalid_end", 64'(p1_rvalid), 64'h0);
    check("t2_rdata_hold", 64'(p1_rdata), 64'h12345678);

    // 3: simultaneous reads held for 4 transactions
    p0_valid = 1; p0_rw = 0; p0_addr = 23'h000200;
    p1_valid = 1; p1_rw = 0; p1_addr = 23'h000300;
    for (int t = 0; t < 4; t++) begin
`ifdef SDRAM_ARB_RR_EN
      exp_g = t[0];
`else
      exp_g = 1'b0;
`endif
      wait_issue(ok);
      check("t3_issue", 64'(ok), 64'h1);
      check("t3_grant", 64'({p1_ready, p0_ready}), exp_g ? 64'h2 : 64'h1);
      check("t3_addr", 64'(sd_user_addr), exp_g ? 64'h300 : 64'h200);
      step();
      sd_out_valid = 1; sd_data_out = 32'hA0000000 + 32'(t);
      step();
      sd_out_valid = 0;
      check("t3_rvalid", 64'({p1_rvalid, p0_rvalid}), exp_g ? 64'h2 : 64'h1);
      check("t3_rdata", 64'(exp_g ? p1_rdata : p0_rdata), 64'hA0000000 + 64'(t));
    end
    p0_valid = 0;
    wait_issue(ok);
    check("t3_p1_after", 64'({ok, p1_ready, p0_ready}), 64'h6);
    p1_valid = 0;
    step();
    sd_out_valid = 1; sd_data_out = 32'h0000_0055;
    step();
    sd_out_valid = 0;
    check("t3_p1_rdata", 64'({p1_rvalid, p1_rdata}), {31'h0, 1'b1, 32'h55});

    // 4: timeout, then a stray late response
    p0_valid = 1; p0_rw = 0; p0_addr = 23'h000400;
    wait_issue(ok);
    check("t4_issue", 64'({ok, p0_ready}), 64'h3);
    p0_valid = 0;
    hits = 0;
    for (int k = 1; k <= RD_TO; k++) begin
      step();
      if (p0_rvalid) hits++;
    end
    check("t4_early_rvalid", 64'(hits), 64'h0);
    step();
    check("t4_rvalid", 64'(p0_rvalid), 64'h1);
    check("t4_err", 64'(p0_err), 64'h1);
    check("t4_rdata", 64'(p0_rdata), 64'hDEADBEEF);
    step();
    sd_out_valid = 1; sd_data_out = 32'h11112222;
    step();
    sd_out_valid = 0;
    hits = 0;
    for (int k = 0; k < 3; k++) begin
      if (p0_rvalid || p1_rvalid) hits++;
      step();
    end
    check("t4_stray_ignored", 64'(hits), 64'h0);
    check("t4_err_hold", 64'({p0_err, p0_rdata}), {31'h0, 1'b1, 32'hDEADBEEF});

    // 4b: response on the timeout cycle wins
    p1_valid = 1; p1_rw = 0; p1_addr = 23'h000500;
    wait_issue(ok);
    check("t4b_issue", 64'({ok, p1_ready}), 64'h3);
    p1_valid = 0;
    for (int k = 1; k <= RD_TO; k++) step();
    check("t4b_no_early", 64'(p1_rvalid), 64'h0);
    sd_out_valid = 1; sd_data_out = 32'hCAFEF00D;
    step();
    sd_out_valid = 0;
    check("t4b_rvalid_err", 64'({p1_rvalid, p1_err}), 64'h2);
    check("t4b_rdata", 64'(p1_rdata), 64'hCAFEF00D);

    // 5: busy blocks issue
    step();
    sd_busy = 1;
    p0_valid = 1; p0_rw = 1; p0_addr = 23'h000600; p0_wdata = 32'h0BADF00D;
    hits = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (sd_in_valid || p0_ready) hits++;
    end
    check("t5_busy_hold", 64'(hits), 64'h0);
    sd_busy = 0;
    step();
    check("t5_issue", 64'({sd_in_valid, p0_ready}), 64'h3);
    check("t5_addr", 64'(sd_user_addr), 64'h600);
    p0_valid = 0;
    step();

    // 6: reset during WAIT_RD
    p1_valid = 1; p1_rw = 0; p1_addr = 23'h000700;
    wait_issue(ok);
    check("t6_issue", 64'(ok), 64'h1);
    p1_valid = 0;
    step();
    step();
    #2;
    rst = 1;
    #1;
    flags = {sd_in_valid, sd_rw, p0_ready, p0_rvalid, p0_err, p1_ready, p1_rvalid, p1_err};
    check("t6_rst_flags", 64'(flags), 64'h0);
    check("t6_rst_addr", 64'(sd_user_addr), 64'h0);
    check("t6_rst_rdata", {p0_rdata, p1_rdata}, 64'h0);
    step();
    step();
    rst = 0;
    sd_out_valid = 1; sd_data_out = 32'h77777777;
    step();
    sd_out_valid = 0;
    step();
    check("t6_no_rvalid", 64'({p0_rvalid, p1_rvalid}), 64'h0);
    p0_valid = 1; p0_rw = 1; p0_addr = 23'h000123; p0_wdata = 32'h00C0FFEE;
    step();
    check("t6_reissue", 64'({sd_in_valid, p0_ready}), 64'h3);
    check("t6_reissue_data", 64'(sd_data_in), 64'h00C0FFEE);
    p0_valid = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
